buzz_seq: RTL
=============

# buzz_seq

Parametrised buzzer pattern sequencer driving the active-low piezo `beep` pin. It generates a square-wave tone with a programmable half-period, gated into bursts. A burst is a programmable count of beeps with programmable on/off lengths and an inter-burst gap. Three modes are supported: continuous tone, one-shot burst with completion pulse, and repeating bursts. It sits between the board/control logic that drives `sel` and the buzzer output pad.

## Interface
- `TONE_W`, default 16: width of `tone_half`, the tone half-period in clocks.
- `DUR_W`, default 8: width of `on_len`, `off_len` and `gap_len`, all in ticks.
- `NUM_W`, default 4: width of `beep_num`.
- `TICK_DIV`, default 50000: clocks per duration tick; must be ≥1.
- `clk` in 1: system clock; all logic on rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `sel` in 2: mode select.
  - 00: off.
  - 01: continuous tone.
  - 10: one-shot burst.
  - 11: repeating bursts.
- `tone_half` in TONE_W: tone half-period in clocks; 0 is treated as 1.
- `on_len` in DUR_W: beep-on length in ticks; 0 is treated as 1.
- `off_len` in DUR_W: silence between beeps in ticks; 0 is treated as 1.
- `gap_len` in DUR_W: extra silence between bursts in mode 11 only; 0 is treated as 1.
- `beep_num` in NUM_W: beeps per burst; 0 is treated as 1.
- `beep` out 1: buzzer drive, active-low (0 = pin low).
- `busy` out 1: high whenever the state is not IDLE.
- `done` out 1: one-clock pulse when a mode-10 burst completes.

## Operation
- States: IDLE, CONT, ON, OFF, GAP. "Sounding" means the state is CONT or ON.
- Configuration (`tone_half`, `on_len`, `off_len`, `gap_len`, `beep_num`) and `sel` are latched into `mode_q`/cfg on leaving IDLE. Input changes after that are ignored until the next IDLE exit.
- IDLE exits:
  - `sel`=01 → CONT.
  - `sel`=11 → ON.
  - `sel`=10 → ON, only while `armed`=1.
- `armed` behaviour:
  - `armed` clears when a mode-10 run starts.
  - `armed` sets on any cycle where `sel`≠10.
  - Holding `sel`=10 therefore yields exactly one burst.
- ON lasts on_len ticks, then → OFF.
- OFF lasts off_len ticks, then:
  - beeps remaining >1 → ON, with remaining decremented.
  - otherwise, mode 10 → IDLE with `done`=1 for that one cycle.
  - otherwise, mode 11 → GAP.
- GAP lasts gap_len ticks, then → ON, with remaining reloaded to beep_num.
- CONT holds until an abort.
- Abort: if the state is not IDLE and `sel`≠`mode_q`, go to IDLE on the next edge. No `done` is issued. A new run may start from IDLE on the following edge.
- Tick prescaler counts 0..TICK_DIV-1 and clears on every state entry, so each state lasts exactly len×TICK_DIV clocks.
- Tone counter counts 0..tone_half-1 and toggles `phase` at terminal count.
  - On entry to a sounding state, the counter clears and `phase`=1.
  - Outside sounding states, `phase`=0.
- `beep` = !(phase), registered; it depends on no input combinationally.
- Counters use natural wrap widths: the prescaler is wide enough for TICK_DIV-1, and duration counters are DUR_W bits.

## Timing
- Reset values: state=IDLE, `beep`=1, `busy`=0, `done`=0, `armed`=1, all counters 0.
- Reset takes effect immediately (asynchronous); it is released synchronously by the design's reset bridge. Reset mid-burst forces `beep`=1 at once.
- Entry latency: `sel` changes before edge k; the state and `busy` change at edge k. The `beep` low for the first half-period is visible from edge k.
- `beep` toggles every tone_half clocks while sounding.
- On leaving a sounding state, `beep` returns to 1 on the same edge as the state change.
- `done` is asserted in the first IDLE cycle, together with `busy`=0.
- With `sel` held at 11, a burst period is beep_num×(on_len+off_len)×TICK_DIV + gap_len×TICK_DIV clocks.

## Test plan
Parameters for all scenarios: TICK_DIV=4, tone_half=2, on_len=3, off_len=2, beep_num=2, gap_len=5.

- **Reset:** assert `rst_n`=0 mid-ON → `beep`=1, `busy`=0, `done`=0 immediately; after release with `sel`=00, stays IDLE.
- **Mode 10:** set `sel`=10 at edge 0.
  - `beep` low during clocks 0-1, high 2-3, repeating for 12 clocks (ON), then high for 8.
  - Second ON runs 20-31, OFF 32-39.
  - `done`=1 at clock 40 only; `busy` falls at 40.
  - Holding `sel`=10 afterwards → no retrigger.
  - `sel`=00 for 1 cycle then 10 → new burst.
- **Mode 11:** same config → GAP of 20 clocks after the second OFF.
  - Pattern period is 60 clocks; the first ON of cycle 2 starts at clock 60.
  - `done` never asserted.
- **Mode 01:** `beep` square wave with period 4 clocks indefinitely.
  - Changing `tone_half` mid-run has no effect.
  - `sel`→00 → `beep`=1 and `busy`=0 at the next edge.
- **Abort/switch:** `sel` 10→11 at clock 15 → IDLE at edge 16, `done`=0.
  - ON restarts at edge 17 with freshly latched config.
- **Zero config:** tone_half=0, on_len=0, off_len=0, beep_num=0 in mode 10 → one beep with `beep` toggling every clock for 4 clocks, OFF for 4, then `done` at clock 8.

Source files
------------

// File: rtl/buzz_seq.sv
// Buzzer pattern sequencer: square-wave tone gated into programmable bursts,
// with continuous, one-shot and repeating modes driving an active-low pin.
module buzz_seq #(
    parameter int TONE_W   = 16,
    parameter int DUR_W    = 8,
    parameter int NUM_W    = 4,
    parameter int TICK_DIV = 50000
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [1:0]        sel,
    input  logic [TONE_W-1:0] tone_half,
    input  logic [DUR_W-1:0]  on_len,
    input  logic [DUR_W-1:0]  off_len,
    input  logic [DUR_W-1:0]  gap_len,
    input  logic [NUM_W-1:0]  beep_num,
    output logic              beep,
    output logic              busy,
    output logic              done
);

    localparam int PRESC_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PRESC_W-1:0] PRESC_LAST = PRESC_W'(TICK_DIV - 1);

    localparam logic [1:0] MODE_CONT    = 2'b01;
    localparam logic [1:0] MODE_ONESHOT = 2'b10;
    localparam logic [1:0] MODE_REPEAT  = 2'b11;

    typedef enum logic [2:0] {
        S_IDLE,
        S_CONT,
        S_ON,
        S_OFF,
        S_GAP
    } state_t;

    state_t              state_q, state_d;
    logic [1:0]          mode_q;
    logic [TONE_W-1:0]   tone_half_q;
    logic [DUR_W-1:0]    on_len_q, off_len_q, gap_len_q;
    logic [NUM_W-1:0]    beep_num_q;
    logic [NUM_W-1:0]    rem_q;
    logic [PRESC_W-1:0]  presc_q;
    logic [DUR_W-1:0]    dur_q;
    logic [TONE_W-1:0]   tone_q;
    logic                phase_q, phase_d;
    logic                beep_q, beep_d;
    logic                done_q;
    logic                armed_q;
    logic                complete;
    logic [1:0]          rst_sync_q;
    logic                rst_int_n;

    // Reset asserts immediately but is released two edges after rst_n rises.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rst_sync_q <= 2'b00;
        end else begin
            rst_sync_q <= {rst_sync_q[0], 1'b1};
        end
    end
    assign rst_int_n = rst_sync_q[1];

    logic [TONE_W-1:0] tone_half_eff;
    logic [DUR_W-1:0]  on_len_eff, off_len_eff, gap_len_eff;
    logic [NUM_W-1:0]  beep_num_eff;

    assign tone_half_eff = (tone_half == '0) ? TONE_W'(1) : tone_half;
    assign on_len_eff    = (on_len    == '0) ? DUR_W'(1)  : on_len;
    assign off_len_eff   = (off_len   == '0) ? DUR_W'(1)  : off_len;
    assign gap_len_eff   = (gap_len   == '0) ? DUR_W'(1)  : gap_len;
    assign beep_num_eff  = (beep_num  == '0) ? NUM_W'(1)  : beep_num;

    logic             tick;
    logic             dur_end;
    logic             tone_end;
    logic             start;
    logic             abort;
    logic             entry;
    logic             sounding_d;
    logic             leave_idle;
    logic [DUR_W-1:0] len_cur;

    always_comb begin
        // NOTE: every always_comb output gets a default first so no latch is inferred.
        len_cur = DUR_W'(1);
        case (state_q)
            S_ON:    len_cur = on_len_q;
            S_OFF:   len_cur = off_len_q;
            S_GAP:   len_cur = gap_len_q;
            default: len_cur = DUR_W'(1);
        endcase
    end

    assign tick     = (presc_q == PRESC_LAST);
    assign dur_end  = tick && (dur_q == len_cur - DUR_W'(1));
    assign tone_end = (tone_q == tone_half_q - TONE_W'(1));
    assign start    = (state_q == S_IDLE) &&
                      ((sel == MODE_CONT) || (sel == MODE_REPEAT) ||
                       ((sel == MODE_ONESHOT) && armed_q));
    assign abort    = (state_q != S_IDLE) && (sel != mode_q);

    always_ff @(posedge clk or negedge rst_int_n) begin
        if (!rst_int_n) begin
            state_q <= S_IDLE;
        end else begin
            // NOTE: sequential state uses non-blocking assignments only.
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        complete = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = (sel == MODE_CONT) ? S_CONT : S_ON;
                end
            end
            S_CONT: state_d = S_CONT;
            S_ON: begin
                if (dur_end) state_d = S_OFF;
            end
            S_OFF: begin
                if (dur_end) begin
                    if (rem_q > NUM_W'(1)) begin
                        state_d = S_ON;
                    end else if (mode_q == MODE_ONESHOT) begin
                        state_d  = S_IDLE;
                        complete = 1'b1;
                    end else begin
                        state_d = S_GAP;
                    end
                end
            end
            S_GAP: begin
                if (dur_end) state_d = S_ON;
            end
            default: state_d = S_IDLE;
        endcase
        if (abort) begin
            state_d  = S_IDLE;
            complete = 1'b0;
        end
    end

    always_comb begin
        busy       = (state_q != S_IDLE);
        entry      = (state_d != state_q);
        leave_idle = (state_q == S_IDLE) && (state_d != S_IDLE);
        sounding_d = (state_d == S_CONT) || (state_d == S_ON);
        phase_d    = 1'b0;
        if (sounding_d) begin
            if (entry)         phase_d = 1'b1;
            else if (tone_end) phase_d = ~phase_q;
            else               phase_d = phase_q;
        end
        beep_d = ~phase_d;
    end

    always_ff @(posedge clk or negedge rst_int_n) begin
        if (!rst_int_n) begin
            mode_q      <= 2'b00;
            tone_half_q <= '0;
            on_len_q    <= '0;
            off_len_q   <= '0;
            gap_len_q   <= '0;
            beep_num_q  <= '0;
            rem_q       <= '0;
            presc_q     <= '0;
            dur_q       <= '0;
            tone_q      <= '0;
            phase_q     <= 1'b0;
            beep_q      <= 1'b1;
            done_q      <= 1'b0;
            armed_q     <= 1'b1;
        end else begin
            if (leave_idle) begin
                mode_q      <= sel;
                tone_half_q <= tone_half_eff;
                on_len_q    <= on_len_eff;
                off_len_q   <= off_len_eff;
                gap_len_q   <= gap_len_eff;
                beep_num_q  <= beep_num_eff;
                rem_q       <= beep_num_eff;
            end else if ((state_q == S_OFF) && (state_d == S_ON)) begin
                rem_q <= rem_q - NUM_W'(1);
            end else if ((state_q == S_GAP) && (state_d == S_ON)) begin
                rem_q <= beep_num_q;
            end

            // Duration counters restart on every state entry so each state is exact.
            if (entry || (state_d == S_IDLE)) begin
                presc_q <= '0;
                dur_q   <= '0;
            end else if (tick) begin
                presc_q <= '0;
                dur_q   <= dur_q + DUR_W'(1);
            end else begin
                presc_q <= presc_q + PRESC_W'(1);
            end

            if (entry || !sounding_d || tone_end) begin
                tone_q <= '0;
            end else begin
                tone_q <= tone_q + TONE_W'(1);
            end

            phase_q <= phase_d;
            beep_q  <= beep_d;
            done_q  <= complete;

            if (sel != MODE_ONESHOT) begin
                armed_q <= 1'b1;
            end else if (start) begin
                armed_q <= 1'b0;
            end
        end
    end

    assign beep = beep_q;
    assign done = done_q;

endmodule
